bcd_digit_entry: RTL and testbench
==================================

BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, defining the consecutive stable cycles needed to accept a press or a release (legal range 2..255).
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-004 Port key_any, input, 1, high when any decimal key line is active (OR of the ten key lines).
REQ-005 Port bcd_in, input, 4, the BCD code of the highest-priority active key, produced by the upstream decimal-to-BCD priority encoder.
REQ-006 Port clr, input, 1, synchronous clear of the entry buffer.
REQ-007 Port digits, output, 16, four BCD digits; [3:0] is the most recently entered digit.
REQ-008 Port count, output, 3, number of digits held, 0..4.
REQ-009 Port full, output, 1, high when count==4.
REQ-010 Port new_digit, output, 1, one-cycle pulse when a digit is shifted in.
REQ-011 Port overflow, output, 1, one-cycle pulse when a press is accepted while full.

Function
REQ-012 The FSM SHALL have three states: IDLE, DEBOUNCE and HELD, plus an 8-bit stability counter cnt and a 4-bit capture register cap.
REQ-013 IDLE SHALL go to DEBOUNCE with cap<=bcd_in and cnt<=1 when key_any==1 and bcd_in<=9; otherwise it SHALL stay in IDLE.
REQ-014 DEBOUNCE SHALL return to IDLE, with no output change, on any edge where key_any==0 or bcd_in!=cap.
REQ-015 In DEBOUNCE, when key_any==1, bcd_in==cap and cnt==DEBOUNCE_CYCLES-1, the press SHALL be accepted: commit per REQ-017/018, go to HELD, cnt<=0.
REQ-016 In DEBOUNCE, when key_any==1, bcd_in==cap and cnt<DEBOUNCE_CYCLES-1, the FSM SHALL stay and increment cnt.
REQ-017 Commit with count<4 SHALL set digits<={digits[11:0],cap} and count<=count+1, and drive new_digit high for exactly the following cycle.
REQ-018 Commit with count==4 SHALL leave digits and count unchanged, drive overflow high for exactly the following cycle, and keep new_digit low.
REQ-019 Accepted latency SHALL be DEBOUNCE_CYCLES edges from the first edge sampling a stable key; the press is accepted on the DEBOUNCE_CYCLES-th consecutive valid sample.
REQ-020 HELD SHALL increment cnt on each edge with key_any==0 and reset cnt to 0 on each edge with key_any==1.
REQ-021 HELD SHALL go to IDLE when key_any==0 and cnt==DEBOUNCE_CYCLES-1; a held key SHALL never produce a second digit.
REQ-022 The full output SHALL be combinational (count==4); count SHALL never exceed 4.
REQ-023 clr==1 SHALL set digits<=0 and count<=0, suppress new_digit and overflow, and force state<=HELD with cnt<=0, so a key held across clr is not re-entered.
REQ-024 clr SHALL take priority over a commit on the same edge; the commit is discarded.
REQ-025 A bcd_in value from 10 to 15 SHALL never be captured or committed.

Reset
REQ-026 While rst_n==0: state=IDLE, cnt=0, cap=0, digits=16'h0000, count=0, new_digit=0, overflow=0, full=0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard the pending press.
REQ-028 After release of rst_n, a key already held SHALL be treated as a new press, debounced from IDLE.

Verification
REQ-029 With DEBOUNCE_CYCLES=4, hold key_any=1 and bcd_in=7 for 10 cycles, then release for 4 cycles -> exactly one new_digit pulse, 4 edges after the first sample; digits=16'h0007, count=1.
REQ-030 Press 1,2,3,4,5 in turn (each held 6 cycles, released 6) -> digits=16'h1234, count=4, full=1, four new_digit pulses, one overflow pulse on the fifth press.
REQ-031 Bounce: key_any high 2 cycles, low 1, high 2 -> no new_digit; then a stable press of 9 -> digits[3:0]=9.
REQ-032 Code change mid-debounce (bcd_in 3 then 5 after 2 cycles, then 5 stable) -> only 5 is committed.
REQ-033 Assert clr on the commit edge while the key is held -> digits=0, count=0, no pulse, no re-entry until release plus 4 idle cycles.
REQ-034 Drop rst_n asynchronously mid-DEBOUNCE with count=2 -> all outputs 0 immediately; no pulse after rst_n rises while the key is low.

Source files
------------

// File: rtl/bcd_digit_entry.sv
// Debounced decimal keypad entry: shifts each accepted key's BCD code into a 4-digit buffer.
// Latency: a press is committed DEBOUNCE_CYCLES edges after the first stable sample; new_digit/overflow follow one cycle later.
// Backpressure: none; presses arriving while the buffer is full raise overflow and are dropped.
module bcd_digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_any,
    input  logic [3:0]  bcd_in,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic        full,
    output logic        new_digit,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Terminal value of the stability counter for both press and release.
    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  cap_q, cap_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic        new_digit_q, new_digit_d;
    logic        overflow_q, overflow_d;
    logic        commit;

    // Next-state, debounce counting, commit and clear handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        digits_d    = digits_q;
        count_d     = count_q;
        new_digit_d = 1'b0;
        overflow_d  = 1'b0;
        commit      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Codes 10..15 are not decimal keys and are never captured.
                if (key_any && (bcd_in <= 4'd9)) begin
                    state_d = DEBOUNCE;
                    cap_d   = bcd_in;
                    cnt_d   = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (!key_any || (bcd_in != cap_q)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = HELD;
                    cnt_d   = 8'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                // Any activity restarts the release count, so a held key
                // cannot be re-entered until it is cleanly released.
                if (key_any) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (commit) begin
            if (count_q == 3'd4) begin
                overflow_d = 1'b1;
            end else begin
                digits_d    = {digits_q[11:0], cap_q};
                count_d     = count_q + 3'd1;
                new_digit_d = 1'b1;
            end
        end

        // Clear wins over a same-edge commit; parking in HELD stops a key
        // that is still down from being entered again.
        if (clr) begin
            digits_d    = 16'h0000;
            count_d     = 3'd0;
            new_digit_d = 1'b0;
            overflow_d  = 1'b0;
            state_d     = HELD;
            cnt_d       = 8'd0;
        end
    end

    // State and output registers; reset drops any pending press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            cap_q       <= 4'd0;
            digits_q    <= 16'h0000;
            count_q     <= 3'd0;
            new_digit_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            new_digit_q <= new_digit_d;
            overflow_q  <= overflow_d;
        end
    end

    assign digits    = digits_q;
    assign count     = count_q;
    assign full      = (count_q == 3'd4);
    assign new_digit = new_digit_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
module tb_bcd_digit_entry;

    logic        clk;
    logic        rst_n;
    logic        key_any;
    logic [3:0]  bcd_in;
    logic        clr;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        full;
    logic        new_digit;
    logic        overflow;

    int checks;
    int failures;
    int cyc;
    int nd_cnt;
    int ov_cnt;
    int first_nd;

    bcd_digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_any   (key_any),
        .bcd_in    (bcd_in),
        .clr       (clr),
        .digits    (digits),
        .count     (count),
        .full      (full),
        .new_digit (new_digit),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; outputs are observed at each falling edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (new_digit) begin
                nd_cnt++;
                if (first_nd < 0) first_nd = cyc;
            end
            if (overflow) ov_cnt++;
        end
    endtask

    task automatic clear_counts();
        nd_cnt   = 0;
        ov_cnt   = 0;
        first_nd = -1;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int rel);
        key_any = 1'b1;
        bcd_in  = d;
        run(hold);
        key_any = 1'b0;
        bcd_in  = 4'd0;
        run(rel);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        run(1);
        clr = 1'b0;
        run(5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_any = 1'b0; bcd_in = 4'd0; clr = 1'b0;
        #12;
        checks++;
        if (digits !== 16'h0000 || count !== 3'd0 || full !== 1'b0 ||
            new_digit !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: digits=%h count=%0d full=%b nd=%b ov=%b, required all zero",
                     digits, count, full, new_digit, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
    endtask

    task automatic test_single_press();
        int c0;
        clear_counts();
        c0 = cyc;
        press(4'd7, 10, 4);
        checks++;
        if (nd_cnt !== 1) begin
            failures++;
            $display("FAIL single_pulse_count: got %0d, required 1", nd_cnt);
        end
        checks++;
        if (first_nd - c0 !== 4) begin
            failures++;
            $display("FAIL single_latency: got %0d, required 4", first_nd - c0);
        end
        checks++;
        if (digits !== 16'h0007 || count !== 3'd1) begin
            failures++;
            $display("FAIL single_value: digits=%h count=%0d, required 0007/1", digits, count);
        end
    endtask

    task automatic test_fill_overflow();
        do_clr();
        clear_counts();
        for (int k = 1; k <= 4; k++) press(4'(k), 6, 6);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || ov_cnt !== 0) begin
            failures++;
            $display("FAIL fill_full: full=%b count=%0d ov=%0d, required 1/4/0", full, count, ov_cnt);
        end
        press(4'd5, 6, 6);
        checks++;
        if (digits !== 16'h1234 || count !== 3'd4 || full !== 1'b1) begin
            failures++;
            $display("FAIL fill_value: digits=%h count=%0d full=%b, required 1234/4/1", digits, count, full);
        end
        checks++;
        if (nd_cnt !== 4 || ov_cnt !== 1) begin
            failures++;
            $display("FAIL fill_pulses: nd=%0d ov=%0d, required 4/1", nd_cnt, ov_cnt);
        end
    endtask

    task automatic test_bounce();
        do_clr();
        clear_counts();
        key_any = 1'b1; bcd_in = 4'd9; run(2);
        key_any = 1'b0; run(1);
        key_any = 1'b1; run(2);
        key_any = 1'b0; bcd_in = 4'd0; run(3);
        checks++;
        if (nd_cnt !== 0 || count !== 3'd0 || full !== 1'b0) begin
            failures++;
            $display("FAIL bounce_reject: nd=%0d count=%0d full=%b, required 0/0/0", nd_cnt, count, full);
        end
        press(4'd9, 6, 6);
        checks++;
        if (digits[3:0] !== 4'd9 || count !== 3'd1 || nd_cnt !== 1) begin
            failures++;
            $display("FAIL bounce_then_stable: digit=%0d count=%0d nd=%0d, required 9/1/1",
                     digits[3:0], count, nd_cnt);
        end
    endtask

    task automatic test_code_change();
        clear_counts();
        key_any = 1'b1; bcd_in = 4'd3; run(2);
        bcd_in = 4'd5; run(6);
        key_any = 1'b0; bcd_in = 4'd0; run(6);
        checks++;
        if (digits !== 16'h0095 || count !== 3'd2 || nd_cnt !== 1) begin
            failures++;
            $display("FAIL code_change: digits=%h count=%0d nd=%0d, required 0095/2/1", digits, count, nd_cnt);
        end
    endtask

    task automatic test_clr_on_commit();
        clear_counts();
        key_any = 1'b1; bcd_in = 4'd2; run(3);
        clr = 1'b1; run(1);
        clr = 1'b0;
        checks++;
        if (digits !== 16'h0000 || count !== 3'd0 || new_digit !== 1'b0) begin
            failures++;
            $display("FAIL clr_commit_edge: digits=%h count=%0d nd=%b, required 0000/0/0", digits, count, new_digit);
        end
        run(5);
        key_any = 1'b0; run(2);
        key_any = 1'b1; run(6);
        key_any = 1'b0; bcd_in = 4'd0; run(6);
        checks++;
        if (nd_cnt !== 0 || ov_cnt !== 0 || count !== 3'd0) begin
            failures++;
            $display("FAIL clr_no_reentry: nd=%0d ov=%0d count=%0d, required 0/0/0", nd_cnt, ov_cnt, count);
        end
        press(4'd2, 6, 6);
        checks++;
        if (digits !== 16'h0002 || count !== 3'd1 || nd_cnt !== 1) begin
            failures++;
            $display("FAIL clr_after_release: digits=%h count=%0d nd=%0d, required 0002/1/1", digits, count, nd_cnt);
        end
    endtask

    task automatic test_invalid_code();
        clear_counts();
        press(4'd12, 6, 6);
        press(4'd15, 6, 6);
        checks++;
        if (nd_cnt !== 0 || digits !== 16'h0002 || count !== 3'd1) begin
            failures++;
            $display("FAIL invalid_code: nd=%0d digits=%h count=%0d, required 0/0002/1", nd_cnt, digits, count);
        end
    endtask

    task automatic test_reset_mid_debounce();
        press(4'd3, 6, 6);
        checks++;
        if (count !== 3'd2 || digits !== 16'h0023) begin
            failures++;
            $display("FAIL pre_reset_state: digits=%h count=%0d, required 0023/2", digits, count);
        end
        clear_counts();
        key_any = 1'b1; bcd_in = 4'd8; run(2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (digits !== 16'h0000 || count !== 3'd0 || full !== 1'b0 ||
            new_digit !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: digits=%h count=%0d full=%b nd=%b ov=%b, required all zero",
                     digits, count, full, new_digit, overflow);
        end
        key_any = 1'b0; bcd_in = 4'd0;
        run(2);
        rst_n = 1'b1;
        run(8);
        checks++;
        if (nd_cnt !== 0 || ov_cnt !== 0 || digits !== 16'h0000 || count !== 3'd0) begin
            failures++;
            $display("FAIL reset_discard: nd=%0d ov=%0d digits=%h count=%0d, required 0/0/0000/0",
                     nd_cnt, ov_cnt, digits, count);
        end
    endtask

    task automatic test_held_through_reset();
        int c0;
        rst_n = 1'b0;
        key_any = 1'b1; bcd_in = 4'd6;
        run(2);
        clear_counts();
        rst_n = 1'b1;
        c0 = cyc;
        run(6);
        key_any = 1'b0; bcd_in = 4'd0;
        run(6);
        checks++;
        if (nd_cnt !== 1 || first_nd - c0 !== 4) begin
            failures++;
            $display("FAIL held_through_reset: nd=%0d latency=%0d, required 1/4", nd_cnt, first_nd - c0);
        end
        checks++;
        if (digits !== 16'h0006 || count !== 3'd1) begin
            failures++;
            $display("FAIL held_reset_value: digits=%h count=%0d, required 0006/1", digits, count);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        clear_counts();
        test_reset();
        test_single_press();
        test_fill_overflow();
        test_bounce();
        test_code_change();
        test_clr_on_commit();
        test_invalid_code();
        test_reset_mid_debounce();
        test_held_through_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
